ccc_lock_rst_seq: RTL and testbench
===================================

# ccc_lock_rst_seq

Parametrised lock-qualification and reset-release sequencer for the fabric CCC. It takes the raw PLL `LOCK`, synchronises and filters it, then releases up to `NUM_CH` per-domain active-low resets in a staggered order. It tracks loss of lock, re-asserts all domain resets on loss, and counts loss events for firmware. It sits beside the CCC wrapper in the `*_sb` system block and drives the reset inputs of the processor, AXI and peripheral domains.

## Interface
- `NUM_CH`, 4: number of reset channels, 1..8.
- `FILT_CYCLES`, 1024: consecutive synchronised-lock cycles required before release, ≥1.
- `STAGGER`, 16: cycles between successive channel releases, ≥1.
- `CNT_W`, 8: width of the loss counter, 1..16.

Ports:
- `CLK` in 1: free-running clock, independent of the PLL (RC oscillator or board clock).
- `RESETN` in 1: reset; one clock, reset is synchronous and active-low.
- `PLL_LOCK` in 1: raw CCC `LOCK`, asynchronous to `CLK`.
- `SW_RST_REQ` in 1: single-cycle pulse; restarts the sequence.
- `LOSS_CLR` in 1: single-cycle pulse; clears `LOSS_CNT`.
- `RST_N` out `NUM_CH`: per-domain active-low resets. Bit 0 is released first.
- `READY` out 1: high while all channels are released.
- `LOSS_CNT` out `CNT_W`: saturating count of lock-loss events.
- `STATE` out 2: current FSM state, for debug.

## Operation
- `PLL_LOCK` passes through a 2-flop synchroniser, giving `lock_s`. All logic uses `lock_s` only.
- All outputs are registered.
- Reset values while `RESETN`=0 at a clock edge:
  - `RST_N`=0, `READY`=0, `LOSS_CNT`=0, `STATE`=WAIT_LOCK.
  - Synchroniser flops and all counters are cleared.
  - Assertion of `RESETN` mid-sequence aborts the sequence immediately.
- FSM states and encodings:
  - WAIT_LOCK (00): `RST_N` all 0. Filter counter held at 0. If `lock_s`=1, go to FILTER.
  - FILTER (01): filter counter increments each cycle.
    - If `lock_s`=0, go to WAIT_LOCK and clear the counter; no loss is counted.
    - When the counter equals `FILT_CYCLES`-1, go to RELEASE with channel index=0 and stagger counter=0.
  - RELEASE (10): stagger counter increments each cycle.
    - When it equals `STAGGER`-1: set `RST_N[idx]`=1, increment idx, clear the stagger counter.
    - When the last channel (idx=`NUM_CH`-1) is released, go to RUN and set `READY`=1 on the same edge.
  - RUN (11): hold `RST_N` all 1 and `READY`=1.
- Loss event: `lock_s`=0 while in RELEASE or RUN.
  - Next edge: `RST_N` all 0, `READY`=0, `STATE`=WAIT_LOCK.
  - `LOSS_CNT` increments, saturating at 2^`CNT_W`-1.
- `SW_RST_REQ`=1 in any state: same actions as a loss event, but no count.
  - If it coincides with a loss event, the loss is still counted.
- `LOSS_CLR`=1: `LOSS_CNT`←0. Clear wins over a simultaneous increment.
- Counter widths: `$clog2(max(FILT_CYCLES,2))`, `$clog2(max(STAGGER,2))`, `$clog2(max(NUM_CH,2))`. No counter wraps; each is reset on a state change.

## Timing
- `PLL_LOCK` to `lock_s`: 2 cycles.
- Edges are numbered with `PLL_LOCK` first sampled high at edge 1:
  - `lock_s`=1 at edge 2.
  - FILTER is entered at edge 3.
  - RELEASE is entered at edge 3+`FILT_CYCLES`.
  - `RST_N[k]` rises at edge 3+`FILT_CYCLES`+(k+1)·`STAGGER`.
  - `READY` rises with `RST_N[NUM_CH-1]`.
- Lock loss to `RST_N` fall: `PLL_LOCK` low sampled at edge n gives all `RST_N`=0 at edge n+2. The state leaves RUN, and the other actions take effect, on the same edge as `RST_N` falls.
- `SW_RST_REQ` / `LOSS_CLR` to effect: 1 cycle.
- `RST_N` never glitches. Each bit is a direct flop output.

## Test plan
- Nominal sequence, with `NUM_CH`=3, `FILT_CYCLES`=8, `STAGGER`=4:
  - Stimulus: `PLL_LOCK` rises before edge 1.
  - Required: `RST_N[0]` rises at edge 15, `RST_N[1]` at 19, `RST_N[2]` at 23; `READY`=1 at 23; `STATE`=11.
- Filter glitch: `PLL_LOCK` high for 5 cycles, low for 1, then high.
  - Required: `LOSS_CNT` stays 0; release is timed from the second rise; `RST_N` stays 0 until then.
- Loss in RUN: drop `PLL_LOCK` for 3 cycles.
  - Required: all `RST_N`=0 and `READY`=0 two edges after the drop; `LOSS_CNT`=1; full resequence after relock.
- Loss mid-RELEASE, after `RST_N[0]` has risen: drop `PLL_LOCK`.
  - Required: `RST_N[0]` falls; `LOSS_CNT`=1; `RST_N[1..2]` never rise before relock.
- Saturation and clear, with `CNT_W`=2:
  - Stimulus: 5 loss events.
  - Required: `LOSS_CNT`=3.
  - Then pulse `LOSS_CLR` together with a 6th loss. Required: `LOSS_CNT`=0.
- `SW_RST_REQ` and `RESETN`:
  - `SW_RST_REQ` pulse in RUN → resequence with `LOSS_CNT` unchanged.
  - `RESETN`=0 mid-RELEASE → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/ccc_lock_rst_seq_if.sv
// Signal bundle between the CCC lock/reset sequencer and its system-block neighbours.
// The master side drives lock and requests; the slave side returns resets and status.
interface ccc_lock_rst_seq_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 8
);
    logic              PLL_LOCK;
    logic              SW_RST_REQ;
    logic              LOSS_CLR;
    logic [NUM_CH-1:0] RST_N;
    logic              READY;
    logic [CNT_W-1:0]  LOSS_CNT;
    logic [1:0]        STATE;

    modport master (
        output PLL_LOCK,
        output SW_RST_REQ,
        output LOSS_CLR,
        input  RST_N,
        input  READY,
        input  LOSS_CNT,
        input  STATE
    );

    modport slave (
        input  PLL_LOCK,
        input  SW_RST_REQ,
        input  LOSS_CLR,
        output RST_N,
        output READY,
        output LOSS_CNT,
        output STATE
    );
endinterface

// File: rtl/ccc_lock_rst_seq.sv
// Lock qualification and staggered reset release for the fabric CCC.
// Synchronises PLL lock, filters it, releases per-domain resets in order and counts lock losses.
module ccc_lock_rst_seq #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned FILT_CYCLES = 1024,
    parameter int unsigned STAGGER     = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                CLK,
    input  logic                RESETN,
    ccc_lock_rst_seq_if.slave   bus
);

    localparam int unsigned FW = $clog2((FILT_CYCLES >= 2) ? FILT_CYCLES : 2);
    localparam int unsigned SW = $clog2((STAGGER >= 2) ? STAGGER : 2);
    localparam int unsigned IW = $clog2((NUM_CH >= 2) ? NUM_CH : 2);

    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYCLES - 1);
    localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_CH - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'b00,
        FILTER    = 2'b01,
        RELEASE   = 2'b10,
        RUN       = 2'b11
    } state_e;

    logic [1:0]        sync_q;
    state_e            state_q, state_d;
    logic [FW-1:0]     filt_q, filt_d;
    logic [SW-1:0]     stag_q, stag_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [NUM_CH-1:0] rst_n_q, rst_n_d;
    logic              ready_q, ready_d;
    logic [CNT_W-1:0]  loss_q, loss_d;

    logic lock_s;
    logic loss_evt;

    assign lock_s   = sync_q[1];
    assign loss_evt = !lock_s && ((state_q == RELEASE) || (state_q == RUN));

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            sync_q  <= '0;
            state_q <= WAIT_LOCK;
            filt_q  <= '0;
            stag_q  <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            ready_q <= 1'b0;
            loss_q  <= '0;
        end else begin
            sync_q  <= {sync_q[0], bus.PLL_LOCK};
            state_q <= state_d;
            filt_q  <= filt_d;
            stag_q  <= stag_d;
            idx_q   <= idx_d;
            rst_n_q <= rst_n_d;
            ready_q <= ready_d;
            loss_q  <= loss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        filt_d  = filt_q;
        stag_d  = stag_q;
        idx_d   = idx_q;
        rst_n_d = rst_n_q;
        ready_d = ready_q;

        unique case (state_q)
            WAIT_LOCK: begin
                rst_n_d = '0;
                ready_d = 1'b0;
                filt_d  = '0;
                if (lock_s) begin
                    state_d = FILTER;
                end
            end

            FILTER: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    filt_d  = '0;
                end else if (filt_q == FILT_LAST) begin
                    state_d = RELEASE;
                    filt_d  = '0;
                    stag_d  = '0;
                    idx_d   = '0;
                end else begin
                    filt_d = filt_q + FW'(1);
                end
            end

            RELEASE: begin
                if (stag_q == STAG_LAST) begin
                    stag_d = '0;
                    for (int unsigned k = 0; k < NUM_CH; k++) begin
                        if (idx_q == IW'(k)) begin
                            rst_n_d[k] = 1'b1;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    stag_d = stag_q + SW'(1);
                end
            end

            RUN: begin
                rst_n_d = '1;
                ready_d = 1'b1;
            end

            default: begin
                state_d = WAIT_LOCK;
            end
        endcase

        // Loss and software restart override whatever the state logic decided,
        // including a channel release scheduled on the same edge.
        if (loss_evt || bus.SW_RST_REQ) begin
            state_d = WAIT_LOCK;
            rst_n_d = '0;
            ready_d = 1'b0;
            filt_d  = '0;
            stag_d  = '0;
            idx_d   = '0;
        end
    end

    always_comb begin
        loss_d = loss_q;
        if (bus.LOSS_CLR) begin
            loss_d = '0;
        end else if (loss_evt && (loss_q != '1)) begin
            loss_d = loss_q + CNT_W'(1);
        end
    end

    assign bus.RST_N    = rst_n_q;
    assign bus.READY    = ready_q;
    assign bus.LOSS_CNT = loss_q;
    assign bus.STATE    = state_q;

endmodule

// File: tb/tb_ccc_lock_rst_seq.sv
// Directed bench for ccc_lock_rst_seq with NUM_CH=3, FILT_CYCLES=8, STAGGER=4, CNT_W=2.
// Edges are numbered relative to the first edge that samples PLL_LOCK high.
module tb_ccc_lock_rst_seq;

    logic clk;
    logic rstn;
    int   ncmp;
    int   nerr;

    ccc_lock_rst_seq_if #(.NUM_CH(3), .CNT_W(2)) bus ();

    ccc_lock_rst_seq #(
        .NUM_CH(3),
        .FILT_CYCLES(8),
        .STAGGER(4),
        .CNT_W(2)
    ) dut (
        .CLK(clk),
        .RESETN(rstn),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Steps relative edges start+1..stop of a lock-to-RUN sequence, checking every edge.
    task automatic seq(input int start, input int stop, input int exp_loss);
        logic [31:0] er, es, ey;
        for (int k = start + 1; k <= stop; k++) begin
            adv();
            er = (k >= 23) ? 32'd7 : (k >= 19) ? 32'd3 : (k >= 15) ? 32'd1 : 32'd0;
            es = (k < 3) ? 32'd0 : (k < 11) ? 32'd1 : (k < 23) ? 32'd2 : 32'd3;
            ey = (k >= 23) ? 32'd1 : 32'd0;
            chk($sformatf("rst_n@%0d", k), 32'(bus.RST_N), er);
            chk($sformatf("state@%0d", k), 32'(bus.STATE), es);
            chk($sformatf("ready@%0d", k), 32'(bus.READY), ey);
            chk($sformatf("loss@%0d", k), 32'(bus.LOSS_CNT), 32'(exp_loss));
        end
    endtask

    // From RUN: lock low for three sampling edges, then relock and resequence.
    task automatic loss_in_run(input int exp_loss, input logic clr_with_loss);
        bus.PLL_LOCK = 1'b0;
        adv();
        adv();
        chk("run_hold_rst_n", 32'(bus.RST_N), 32'd7);
        chk("run_hold_state", 32'(bus.STATE), 32'd3);
        bus.LOSS_CLR = clr_with_loss;
        adv();
        bus.LOSS_CLR = 1'b0;
        chk("loss_rst_n", 32'(bus.RST_N), 32'd0);
        chk("loss_ready", 32'(bus.READY), 32'd0);
        chk("loss_state", 32'(bus.STATE), 32'd0);
        chk("loss_cnt", 32'(bus.LOSS_CNT), 32'(exp_loss));
        bus.PLL_LOCK = 1'b1;
        seq(0, 23, exp_loss);
    endtask

    initial begin
        ncmp = 0;
        nerr = 0;
        rstn = 1'b0;
        bus.PLL_LOCK   = 1'b0;
        bus.SW_RST_REQ = 1'b0;
        bus.LOSS_CLR   = 1'b0;
        adv();
        adv();
        chk("reset_rst_n", 32'(bus.RST_N), 32'd0);
        chk("reset_ready", 32'(bus.READY), 32'd0);
        chk("reset_loss", 32'(bus.LOSS_CNT), 32'd0);
        chk("reset_state", 32'(bus.STATE), 32'd0);
        rstn = 1'b1;
        adv();
        adv();
        chk("idle_state", 32'(bus.STATE), 32'd0);

        // Filter glitch: high sampled at edges 1..5, low at 6, high from 7.
        bus.PLL_LOCK = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            adv();
            if (k == 5) bus.PLL_LOCK = 1'b0;
            if (k == 6) bus.PLL_LOCK = 1'b1;
            chk($sformatf("glitch_state@%0d", k), 32'(bus.STATE),
                (k >= 3 && k <= 7) ? 32'd1 : 32'd0);
            chk($sformatf("glitch_rst_n@%0d", k), 32'(bus.RST_N), 32'd0);
            chk($sformatf("glitch_loss@%0d", k), 32'(bus.LOSS_CNT), 32'd0);
        end
        // Edge 8 of the glitch run is relative edge 2 of the second rise.
        seq(2, 23, 0);

        // Loss in RUN, then full resequence.
        loss_in_run(1, 1'b0);

        // Software restart in RUN keeps the loss count.
        bus.SW_RST_REQ = 1'b1;
        adv();
        bus.SW_RST_REQ = 1'b0;
        chk("sw_rst_n", 32'(bus.RST_N), 32'd0);
        chk("sw_state", 32'(bus.STATE), 32'd0);
        chk("sw_loss", 32'(bus.LOSS_CNT), 32'd1);
        seq(2, 23, 1);

        // Clear plus restart together, then loss after RST_N[0] has risen.
        bus.SW_RST_REQ = 1'b1;
        bus.LOSS_CLR   = 1'b1;
        adv();
        bus.SW_RST_REQ = 1'b0;
        bus.LOSS_CLR   = 1'b0;
        chk("clr_sw_loss", 32'(bus.LOSS_CNT), 32'd0);
        chk("clr_sw_state", 32'(bus.STATE), 32'd0);
        seq(2, 16, 0);
        bus.PLL_LOCK = 1'b0;
        adv();
        chk("midrel_rst_n@17", 32'(bus.RST_N), 32'd1);
        adv();
        chk("midrel_rst_n@18", 32'(bus.RST_N), 32'd1);
        adv();
        chk("midrel_rst_n@19", 32'(bus.RST_N), 32'd0);
        chk("midrel_state@19", 32'(bus.STATE), 32'd0);
        chk("midrel_loss@19", 32'(bus.LOSS_CNT), 32'd1);
        bus.PLL_LOCK = 1'b1;
        seq(0, 23, 1);

        // Standalone clear in RUN leaves the channels released.
        bus.LOSS_CLR = 1'b1;
        adv();
        bus.LOSS_CLR = 1'b0;
        chk("clr_loss", 32'(bus.LOSS_CNT), 32'd0);
        chk("clr_state", 32'(bus.STATE), 32'd3);
        chk("clr_rst_n", 32'(bus.RST_N), 32'd7);

        // Saturation: five losses on a 2-bit counter, then clear coinciding with a sixth.
        loss_in_run(1, 1'b0);
        loss_in_run(2, 1'b0);
        loss_in_run(3, 1'b0);
        loss_in_run(3, 1'b0);
        loss_in_run(3, 1'b0);
        loss_in_run(0, 1'b1);

        // RESETN asserted mid-RELEASE with a non-zero loss count.
        loss_in_run(1, 1'b0);
        bus.SW_RST_REQ = 1'b1;
        adv();
        bus.SW_RST_REQ = 1'b0;
        seq(2, 16, 1);
        rstn = 1'b0;
        adv();
        chk("rstn_rst_n", 32'(bus.RST_N), 32'd0);
        chk("rstn_ready", 32'(bus.READY), 32'd0);
        chk("rstn_loss", 32'(bus.LOSS_CNT), 32'd0);
        chk("rstn_state", 32'(bus.STATE), 32'd0);
        rstn = 1'b1;
        seq(0, 23, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
